uart_frame_parser: RTL and testbench

//  Consumes the byte strobe from the UART receiver and extracts framed packets:

---
 rtl/uart_frame_parser_if.sv | 26 ++
 rtl/uart_frame_parser.sv | 168 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
//   Groups the byte-strobe input, the held-frame read port, the frame release
//   and the error report of uart_frame_parser.
//   slave  : parser side (consumes rx bytes, presents frame and errors)
//   master : upstream / command-logic side (drives rx bytes, read index, ack)
interface uart_frame_parser_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_frame_valid;
  logic [7:0] o_frame_len;
  logic [7:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       i_frame_ack;
  logic       o_err;
  logic [1:0] o_err_code;

  modport slave (
    input  i_rx_dv, i_rx_byte, i_rd_addr, i_frame_ack,
    output o_frame_valid, o_frame_len, o_rd_data, o_err, o_err_code
  );

  modport master (
    output i_rx_dv, i_rx_byte, i_rd_addr, i_frame_ack,
    input  o_frame_valid, o_frame_len, o_rd_data, o_err, o_err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Extracts SYNC, LEN, payload, CHK frames from the UART receive byte strobe,
//   verifies the modulo-256 sum of LEN and payload, and holds the payload for
//   random-access reads until the command logic acknowledges it.
// Ports
//   i_clock    : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : uart_frame_parser_if.slave (rx strobe/byte, frame valid/len,
//                read addr/data, frame ack, error pulse/code)
// Optional feature
//   UART_FRAME_TIMEOUT_EN : inter-byte timeout inside a frame (err code 3).
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | hunting for SYNC_BYTE, other bytes discarded silently
// S_LEN     | next strobe is the payload length
// S_PAYLOAD | storing payload bytes into the buffer
// S_CHECK   | next strobe is the checksum
// S_HOLD    | checked frame held, waiting for i_frame_ack
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  uart_frame_parser_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("MAX_LEN must be 1..255");
  end
  if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must fit the 16-bit idle counter");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD
  } state_t;

  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] sum_q;
  logic [7:0] idx_q;
  logic       frame_valid_q;
  logic [7:0] frame_len_q;
  logic       err_q;
  logic [1:0] err_code_q;
  logic [7:0] buf_q [MAX_LEN];

  logic       dv;
  logic [7:0] rx;
  assign dv = bus.i_rx_dv;
  assign rx = bus.i_rx_byte;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [15:0] TO_RELOAD = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] to_cnt_q;
  logic        in_frame;
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dv && rx == SYNC_BYTE) state_q <= S_LEN;
        end
        S_LEN: begin
          if (dv) begin
            if (rx == 8'd0 || rx > 8'(MAX_LEN)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state_q    <= S_IDLE;
            end else begin
              len_q   <= rx;
              sum_q   <= rx;
              idx_q   <= '0;
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (dv) begin
            sum_q <= sum_q + rx;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dv) begin
            if (rx == sum_q) begin
              frame_valid_q <= 1'b1;
              frame_len_q   <= len_q;
              state_q       <= S_HOLD;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK;
              state_q    <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          // Any byte arriving while a frame is held is lost; ack still releases.
          if (dv) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          if (bus.i_frame_ack) begin
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef UART_FRAME_TIMEOUT_EN
      // Down-counter reloaded by every strobe; a strobe on the terminal-count
      // cycle reloads instead of timing out.
      if (dv) begin
        to_cnt_q <= TO_RELOAD;
      end else if (in_frame) begin
        if (to_cnt_q == 16'd0) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
          state_q    <= S_IDLE;
        end else begin
          to_cnt_q <= to_cnt_q - 16'd1;
        end
      end
`endif
    end
  end

  // Payload RAM: no reset; only the current frame's range is ever exposed.
  always_ff @(posedge i_clock) begin
    if (state_q == S_PAYLOAD && dv) buf_q[idx_q[AW-1:0]] <= rx;
  end

  assign bus.o_frame_valid = frame_valid_q;
  assign bus.o_frame_len   = frame_len_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_code    = err_code_q;
  assign bus.o_rd_data     = (frame_valid_q && bus.i_rd_addr < frame_len_q)
                             ? buf_q[bus.i_rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;
  localparam int TIMEOUT_CLKS = 8680;

  logic clk;
  logic rst_n;
  uart_frame_parser_if bus();

  uart_frame_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  logic prev_valid = 1'b0;

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] len);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: every error pulse and every frame_valid rise must match the next
  // expected event in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_err) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL err_event: got err code=%0d, expected no event", bus.o_err_code);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err || e.code != bus.o_err_code) begin
            n_err++;
            $display("FAIL err_event: got err code=%0d, expected is_err=%0d code=%0d len=%0d",
                     bus.o_err_code, e.is_err, e.code, e.len);
          end
        end
      end
      if (bus.o_frame_valid && !prev_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_event: got frame len=%0d, expected no event", bus.o_frame_len);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || e.len != bus.o_frame_len) begin
            n_err++;
            $display("FAIL frame_event: got frame len=%0d, expected is_err=%0d code=%0d len=%0d",
                     bus.o_frame_len, e.is_err, e.code, e.len);
          end
        end
      end
      prev_valid = bus.o_frame_valid;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_drained(input string name);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected events never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = b;
    @(negedge clk);
    bus.i_rx_dv   = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.i_frame_ack = 1'b1;
    @(negedge clk);
    bus.i_frame_ack = 1'b0;
    chk("ack_clears_valid", {7'd0, bus.o_frame_valid}, 8'h00);
  endtask

  // A5 03 11 22 33 69 : sum 03+11+22+33 = 69
  task automatic frame1(input string tag);
    logic [7:0] bytes [6];
    bytes = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    push_frame(8'd3);
    for (int i = 0; i < 5; i++) send(bytes[i]);
    chk({tag, "_valid_before_chk"}, {7'd0, bus.o_frame_valid}, 8'h00);
    send(bytes[5]);
    chk({tag, "_valid_after_chk"}, {7'd0, bus.o_frame_valid}, 8'h01);
    chk({tag, "_len"}, bus.o_frame_len, 8'h03);
  endtask

  initial begin
    logic [7:0] rd_exp [4];
    rd_exp = '{8'h11, 8'h22, 8'h33, 8'h00};

    rst_n           = 1'b0;
    bus.i_rx_dv     = 1'b0;
    bus.i_rx_byte   = 8'h00;
    bus.i_rd_addr   = 8'h00;
    bus.i_frame_ack = 1'b0;
    idle(3);
    chk("reset_valid", {7'd0, bus.o_frame_valid}, 8'h00);
    chk("reset_err", {7'd0, bus.o_err}, 8'h00);
    chk("reset_code", {6'd0, bus.o_err_code}, 8'h00);
    chk("reset_len", bus.o_frame_len, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: good frame, readback, ack
    frame1("t1");
    for (int a = 0; a < 4; a++) begin
      bus.i_rd_addr = 8'(a);
      #1 chk($sformatf("t1_rd%0d", a), bus.o_rd_data, rd_exp[a]);
    end
    ack();
    bus.i_rd_addr = 8'd0;
    #1 chk("t1_rd_after_ack", bus.o_rd_data, 8'h00);
    idle(2);
    chk_drained("t1_drained");

    // 2: bad checksum, then good frame
    push_err(2'd1);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h6A);
    chk("t2_err_pulse", {7'd0, bus.o_err}, 8'h01);
    @(negedge clk);
    chk("t2_err_one_clk", {7'd0, bus.o_err}, 8'h00);
    chk("t2_no_valid", {7'd0, bus.o_frame_valid}, 8'h00);
    frame1("t2");
    ack();
    idle(2);
    chk_drained("t2_drained");

    // 3: junk in IDLE ignored, zero length, too long
    send(8'h00); send(8'hFF);
    send(8'hA5);
    push_err(2'd0);
    send(8'h00);
    chk("t3_len0_err", {7'd0, bus.o_err}, 8'h01);
    push_err(2'd0);
    send(8'hA5); send(8'h11);
    chk("t3_len17_code", {6'd0, bus.o_err_code}, 8'h00);
    idle(2);
    chk_drained("t3_drained");

    // 4: overrun while held, then ack + dv together
    frame1("t4");
    bus.i_rd_addr = 8'd1;
    push_err(2'd2);
    send(8'hA5);
    chk("t4_valid_kept", {7'd0, bus.o_frame_valid}, 8'h01);
    #1 chk("t4_rd_unchanged", bus.o_rd_data, 8'h22);
    push_err(2'd2);
    @(negedge clk);
    bus.i_rx_dv = 1'b1; bus.i_rx_byte = 8'hA5; bus.i_frame_ack = 1'b1;
    @(negedge clk);
    bus.i_rx_dv = 1'b0; bus.i_frame_ack = 1'b0;
    chk("t4_ackdv_valid", {7'd0, bus.o_frame_valid}, 8'h00);
    frame1("t4b");
    ack();
    idle(2);
    chk_drained("t4_drained");

    // 5: silence mid-frame
    send(8'hA5); send(8'h02); send(8'h11);
`ifdef UART_FRAME_TIMEOUT_EN
    push_err(2'd3);
    idle(TIMEOUT_CLKS + 20);
    chk_drained("t5_timeout_seen");
    frame1("t5");
`else
    idle(TIMEOUT_CLKS + 20);
    chk_drained("t5_no_timeout");
    push_frame(8'd2);
    send(8'h22); send(8'h35);
    chk("t5_late_valid", {7'd0, bus.o_frame_valid}, 8'h01);
    chk("t5_late_len", bus.o_frame_len, 8'h02);
`endif
    ack();
    idle(2);
    chk_drained("t5_drained");

    // 6: reset mid-payload, then reset while a frame is held
    send(8'hA5); send(8'h03); send(8'h11);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", {7'd0, bus.o_frame_valid}, 8'h00);
    chk("t6_rst_err", {7'd0, bus.o_err}, 8'h00);
    idle(2);
    rst_n = 1'b1;
    frame1("t6");
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", {7'd0, bus.o_frame_valid}, 8'h00);
    idle(2);
    rst_n = 1'b1;
    frame1("t6b");
    ack();
    idle(2);
    chk_drained("t6_drained");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
